// File: rtl/line_draw_sequencer.sv
// line_draw_sequencer: walks a shape's lines one at a time. It optionally
// clears the framebuffer first, then for each line fetches endpoints from the
// shape source, kicks the rasteriser and forwards its pixels to the
// framebuffer. When MODE=1 it redraws after a number of frame pulses.
module line_draw_sequencer #(
    parameter int XY_BITW       = 11,
    parameter int LINE_CNT      = 12,
    parameter int LINEW         = 4,
    parameter int COLORW        = 3,
    parameter int FB_WIDTH      = 16,
    parameter int FB_HEIGHT     = 16,
    parameter int CLEAR_EN      = 1,
    parameter int MODE          = 0,
    parameter int REDRAW_FRAMES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               frame,
    output logic [LINEW-1:0]   line_id,
    input  logic [XY_BITW-1:0] x0,
    input  logic [XY_BITW-1:0] y0,
    input  logic [XY_BITW-1:0] x1,
    input  logic [XY_BITW-1:0] y1,
    input  logic [COLORW-1:0]  color,
    output logic               draw_start,
    input  logic [XY_BITW-1:0] draw_x,
    input  logic [XY_BITW-1:0] draw_y,
    input  logic               drawing,
    input  logic               draw_done,
    input  logic [XY_BITW-1:0] sx,
    input  logic [XY_BITW-1:0] sy,
    output logic               fb_we,
    output logic [XY_BITW-1:0] fb_x,
    output logic [XY_BITW-1:0] fb_y,
    output logic [COLORW-1:0]  fb_color,
    output logic               busy,
    output logic               done
);

    localparam int FCW = $clog2(REDRAW_FRAMES + 1);

    localparam logic [LINEW-1:0]   LINE_LAST = LINEW'(LINE_CNT - 1);
    localparam logic [XY_BITW-1:0] X_LAST    = XY_BITW'(FB_WIDTH - 1);
    localparam logic [XY_BITW-1:0] Y_LAST    = XY_BITW'(FB_HEIGHT - 1);
    localparam logic [FCW-1:0]     FRM_LAST  = FCW'(REDRAW_FRAMES - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH,
        START,
        DRAW,
        DONE
    } state_t;

    // A new pass begins with the clear sweep only when it is enabled.
    localparam state_t FIRST_STATE = (CLEAR_EN != 0) ? CLEAR : FETCH;

    state_t               state, state_n;
    logic [LINEW-1:0]     line_n;
    logic [FCW-1:0]       frame_cnt, frame_cnt_n;
    logic [XY_BITW-1:0]   clr_x, clr_x_n;
    logic [XY_BITW-1:0]   clr_y, clr_y_n;
    logic [COLORW-1:0]    color_q;

    // Endpoints travel straight from the shape source to the rasteriser;
    // the sequencer only needs to time their fetch.
    logic unused_endpoints;
    assign unused_endpoints = ^{x0, y0, x1, y1};

    // State, line index, frame counter, clear position and latched colour.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            line_id   <= '0;
            frame_cnt <= '0;
            clr_x     <= '0;
            clr_y     <= '0;
            color_q   <= '0;
        end else begin
            state     <= state_n;
            line_id   <= line_n;
            frame_cnt <= frame_cnt_n;
            clr_x     <= clr_x_n;
            clr_y     <= clr_y_n;
            if (state == START) begin
                color_q <= color;
            end
        end
    end

    // Next-state logic; dropping enable outside IDLE always wins.
    always_comb begin
        state_n     = state;
        line_n      = line_id;
        frame_cnt_n = frame_cnt;
        clr_x_n     = clr_x;
        clr_y_n     = clr_y;
        if (state != IDLE && !enable) begin
            state_n     = IDLE;
            frame_cnt_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame && enable) begin
                        line_n  = '0;
                        clr_x_n = '0;
                        clr_y_n = '0;
                        state_n = FIRST_STATE;
                    end
                end
                CLEAR: begin
                    if (clr_x == X_LAST) begin
                        clr_x_n = '0;
                        if (clr_y == Y_LAST) begin
                            state_n = FETCH;
                        end else begin
                            clr_y_n = clr_y + 1'b1;
                        end
                    end else begin
                        clr_x_n = clr_x + 1'b1;
                    end
                end
                FETCH: state_n = START;
                START: state_n = DRAW;
                DRAW: begin
                    if (draw_done) begin
                        if (line_id == LINE_LAST) begin
                            state_n = DONE;
                        end else begin
                            line_n  = line_id + 1'b1;
                            state_n = FETCH;
                        end
                    end
                end
                DONE: begin
                    if (MODE == 1 && frame) begin
                        if (frame_cnt == FRM_LAST) begin
                            frame_cnt_n = '0;
                            line_n      = '0;
                            clr_x_n     = '0;
                            clr_y_n     = '0;
                            state_n     = FIRST_STATE;
                        end else begin
                            frame_cnt_n = frame_cnt + 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the current state so reset takes effect at once.
    always_comb begin
        draw_start = (state == START);
        busy       = (state == CLEAR) || (state == FETCH) ||
                     (state == START) || (state == DRAW);
        done       = (state == DONE);
        fb_we      = 1'b0;
        fb_x       = sx;
        fb_y       = sy;
        fb_color   = color_q;
        case (state)
            CLEAR: begin
                fb_we    = 1'b1;
                fb_x     = clr_x;
                fb_y     = clr_y;
                fb_color = '0;
            end
            DRAW: begin
                fb_we = drawing;
                fb_x  = draw_x;
                fb_y  = draw_y;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_line_draw_sequencer.sv
// Bench for line_draw_sequencer: a scoreboard-based check of the continuous
// redraw configuration with a clear pass, plus a one-shot instance without
// clear.
module tb_line_draw_sequencer;

    localparam int XW = 11;
    localparam int LW = 2;
    localparam int CW = 3;
    localparam int NL = 3;
    localparam int FW = 4;
    localparam int FH = 3;
    localparam int RF = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance signals
    logic          rst, enable, frame;
    logic [LW-1:0] line_id;
    logic [XW-1:0] x0, y0, x1, y1;
    logic [CW-1:0] color;
    logic          draw_start;
    logic [XW-1:0] draw_x, draw_y;
    logic          drawing, draw_done;
    logic [XW-1:0] sx, sy;
    logic          fb_we;
    logic [XW-1:0] fb_x, fb_y;
    logic [CW-1:0] fb_color;
    logic          busy, done;

    // one-shot instance signals
    logic          frame_b, draw_done_b;
    logic [LW-1:0] line_id_b;
    logic          draw_start_b, fb_we_b, busy_b, done_b;
    logic [XW-1:0] fb_x_b, fb_y_b;
    logic [CW-1:0] fb_color_b;

    line_draw_sequencer #(
        .XY_BITW(XW), .LINE_CNT(NL), .LINEW(LW), .COLORW(CW),
        .FB_WIDTH(FW), .FB_HEIGHT(FH), .CLEAR_EN(1), .MODE(1), .REDRAW_FRAMES(RF)
    ) u0 (
        .clk(clk), .rst(rst), .enable(enable), .frame(frame), .line_id(line_id),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color(color), .draw_start(draw_start),
        .draw_x(draw_x), .draw_y(draw_y), .drawing(drawing), .draw_done(draw_done),
        .sx(sx), .sy(sy), .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y),
        .fb_color(fb_color), .busy(busy), .done(done)
    );

    line_draw_sequencer #(
        .XY_BITW(XW), .LINE_CNT(NL), .LINEW(LW), .COLORW(CW),
        .FB_WIDTH(FW), .FB_HEIGHT(FH), .CLEAR_EN(0), .MODE(0), .REDRAW_FRAMES(1)
    ) u1 (
        .clk(clk), .rst(rst), .enable(enable), .frame(frame_b), .line_id(line_id_b),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color(color), .draw_start(draw_start_b),
        .draw_x(draw_x), .draw_y(draw_y), .drawing(1'b0), .draw_done(draw_done_b),
        .sx(sx), .sy(sy), .fb_we(fb_we_b), .fb_x(fb_x_b), .fb_y(fb_y_b),
        .fb_color(fb_color_b), .busy(busy_b), .done(done_b)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // ---------------- reference model state ----------------
    typedef struct packed {
        logic [XW-1:0] x;
        logic [XW-1:0] y;
        logic [CW-1:0] c;
    } pix_t;

    typedef enum int {P_IDLE, P_RUN, P_DONE} phase_t;

    pix_t          exp_q[$];
    int            exp_lines[$];
    phase_t        phase = P_IDLE;
    int            dframes = 0;
    int            pass_base = 0;
    int            pass_frame_cyc = 0;
    int            lines_done = 0;
    int            cyc = 0;
    logic [CW-1:0] ctab [NL];

    always @(posedge clk) cyc <= cyc + 1;

    // shape source: colour/endpoints follow line_id one cycle later
    initial begin
        color = '0; x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        forever begin
            @(posedge clk); #1;
            color = ctab[line_id];
            x0 = XW'($urandom_range(0, 100)); y0 = XW'($urandom_range(0, 100));
            x1 = XW'($urandom_range(0, 100)); y1 = XW'($urandom_range(0, 100));
        end
    end

    // random screen position
    initial begin
        sx = '0; sy = '0;
        forever begin
            @(posedge clk); #1;
            sx = XW'($urandom_range(0, 2047));
            sy = XW'($urandom_range(0, 2047));
        end
    end

    // a new pass: the whole framebuffer cleared to 0, then lines 0..NL-1
    task automatic begin_pass();
        phase          = P_RUN;
        pass_base      = lines_done;
        pass_frame_cyc = cyc;
        ctab[0] = CW'($urandom_range(0, 7));
        ctab[1] = 3'd5;
        ctab[2] = CW'($urandom_range(1, 7));
        for (int y = 0; y < FH; y++)
            for (int x = 0; x < FW; x++)
                exp_q.push_back('{x: XW'(x), y: XW'(y), c: '0});
        for (int l = 0; l < NL; l++) exp_lines.push_back(l);
    endtask

    // one frame pulse; the model decides whether it starts a pass
    task automatic frame_pulse();
        @(posedge clk); #1;
        if (enable && rst) begin
            if (phase == P_IDLE) begin
                begin_pass();
            end else if (phase == P_DONE) begin
                dframes++;
                if (dframes == RF) begin
                    dframes = 0;
                    begin_pass();
                end
            end
        end
        frame = 1'b1;
        @(posedge clk); #1;
        frame = 1'b0;
    endtask

    task automatic wait_lines(input int target);
        int n = 0;
        while (lines_done < target && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check("pass_completes", 32'(lines_done >= target), 1);
    endtask

    // rasteriser model for the main instance
    initial begin
        int     n;
        bit     aborted;
        int     li;
        drawing = 1'b0; draw_done = 1'b0; draw_x = '0; draw_y = '0;
        forever begin
            @(negedge clk);
            if (draw_start && rst && enable) begin
                n       = $urandom_range(1, 5);
                aborted = 0;
                li      = lines_done - pass_base;
                for (int k = 0; k < n && !aborted; k++) begin
                    @(posedge clk); #1;
                    if (!enable || !rst) begin
                        aborted = 1;
                        drawing = 1'b0;
                    end else begin
                        if (k == 0 && li == 1) begin
                            drawing = 1'b1; draw_x = XW'(7); draw_y = XW'(5);
                        end else begin
                            drawing = ($urandom_range(0, 3) != 0);
                            draw_x  = XW'($urandom_range(0, 2047));
                            draw_y  = XW'($urandom_range(0, 2047));
                        end
                        if (drawing) exp_q.push_back('{x: draw_x, y: draw_y, c: ctab[li]});
                    end
                end
                if (!aborted) begin
                    @(posedge clk); #1;
                    drawing = 1'b0;
                    if (enable && rst) begin
                        draw_done = 1'b1;
                        lines_done++;
                        @(posedge clk); #1;
                        draw_done = 1'b0;
                    end
                end
            end
        end
    end

    // monitor: pops expectations whenever the DUT writes or starts a line
    always @(negedge clk) begin
        pix_t p;
        int   l;
        if (rst) begin
            if (fb_we) begin
                check("write_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    p = exp_q.pop_front();
                    check("fb_x", 32'(fb_x), 32'(p.x));
                    check("fb_y", 32'(fb_y), 32'(p.y));
                    check("fb_color", 32'(fb_color), 32'(p.c));
                end
            end
            if (draw_start) begin
                check("start_expected", 32'(exp_lines.size() > 0), 1);
                if (exp_lines.size() > 0) begin
                    l = exp_lines.pop_front();
                    check("line_id", 32'(line_id), 32'(l));
                    if (l == 0) check("first_start_latency", 32'(cyc - pass_frame_cyc), 14);
                end
            end
            if (!busy) begin
                check("idle_no_write", 32'(fb_we), 0);
                check("idle_fb_x", 32'(fb_x), 32'(sx));
                check("idle_fb_y", 32'(fb_y), 32'(sy));
            end
        end
    end

    // one-shot instance: rasteriser finishes each line after one DRAW cycle
    int   starts_b = 0;
    int   ids_b [8];
    int   frame_b_cyc = 0;
    initial begin
        draw_done_b = 1'b0;
        forever begin
            @(negedge clk);
            if (draw_start_b && rst) begin
                if (starts_b < 8) ids_b[starts_b] = int'(line_id_b);
                if (starts_b == 0) check("oneshot_latency", 32'(cyc - frame_b_cyc), 2);
                starts_b++;
                @(posedge clk); #1;
                draw_done_b = 1'b1;
                @(posedge clk); #1;
                draw_done_b = 1'b0;
            end
        end
    end

    task automatic pulse_b();
        @(posedge clk); #1;
        frame_b     = 1'b1;
        frame_b_cyc = cyc;
        @(posedge clk); #1;
        frame_b = 1'b0;
    endtask

    task automatic wait_start(output bit seen);
        int n = 0;
        seen = 0;
        while (!seen && n < 500) begin
            @(negedge clk);
            if (draw_start) seen = 1;
            n++;
        end
    endtask

    initial begin
        bit seen;
        int n;
        rst = 1'b0; enable = 1'b0; frame = 1'b0; frame_b = 1'b0;
        ctab[0] = '0; ctab[1] = '0; ctab[2] = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_we", 32'(fb_we), 0);
        check("rst_start", 32'(draw_start), 0);
        check("rst_line_id", 32'(line_id), 0);
        check("rst_fb_color", 32'(fb_color), 0);
        check("rst_fb_x", 32'(fb_x), 32'(sx));
        rst = 1'b1;

        // frame with enable low is not a start
        frame_pulse();
        repeat (4) @(posedge clk);
        #1 check("disabled_frame_idle", 32'(busy), 0);

        // passes: first from IDLE, later ones every RF-th frame in DONE
        enable = 1'b1;
        for (int p = 0; p < 3; p++) begin
            if (p == 0) begin
                frame_pulse();
            end else begin
                frame_pulse();
                repeat (3) @(posedge clk);
                #1 check("one_frame_no_redraw", 32'(busy), 0);
                check("one_frame_done", 32'(done), 1);
                frame_pulse();
            end
            check("busy_running", 32'(busy), 1);
            frame_pulse();                 // ignored: falls inside CLEAR
            wait_lines(pass_base + NL);
            phase = P_DONE;
            repeat (2) @(posedge clk);
            #1 check("done_flag", 32'(done), 1);
            check("done_not_busy", 32'(busy), 0);
        end

        // abort during line 1, then restart from line 0
        frame_pulse();
        frame_pulse();
        n = 0;
        while ((lines_done - pass_base) < 1 && n < 500) begin @(posedge clk); n++; end
        wait_start(seen);
        check("abort_line1_started", 32'(seen), 1);
        @(posedge clk);
        @(posedge clk);
        #2 enable = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_we", 32'(fb_we), 0);
        check("abort_line_id", 32'(line_id), 1);
        @(posedge clk); #1;
        check("abort_queue_drained", 32'(exp_q.size()), 0);
        exp_lines.delete();
        phase   = P_IDLE;
        dframes = 0;
        enable  = 1'b1;
        frame_pulse();
        wait_lines(pass_base + NL);
        phase = P_DONE;
        repeat (2) @(posedge clk);
        #1 check("restart_done", 32'(done), 1);

        // asynchronous reset mid-CLEAR
        frame_pulse();
        frame_pulse();
        repeat (4) @(posedge clk);
        #1 check("mid_clear_writing", 32'(fb_we), 1);
        #1 rst = 1'b0;
        #1;
        check("arst_we", 32'(fb_we), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_done", 32'(done), 0);
        check("arst_line_id", 32'(line_id), 0);
        check("arst_fb_color", 32'(fb_color), 0);
        check("arst_fb_x", 32'(fb_x), 32'(sx));
        check("arst_fb_y", 32'(fb_y), 32'(sy));
        exp_q.delete();
        exp_lines.delete();
        phase   = P_IDLE;
        dframes = 0;
        repeat (3) @(posedge clk);
        #1 check("arst_held_we", 32'(fb_we), 0);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1 check("post_reset_idle", 32'(busy), 0);
        frame_pulse();
        wait_lines(pass_base + NL);
        phase = P_DONE;
        repeat (2) @(posedge clk);
        #1 check("post_reset_done", 32'(done), 1);
        check("scoreboard_empty", 32'(exp_q.size()), 0);

        // one-shot instance without clear
        pulse_b();
        repeat (30) @(posedge clk);
        #1 check("oneshot_starts", 32'(starts_b), 3);
        for (int i = 0; i < 3; i++) check("oneshot_line_id", 32'(ids_b[i]), 32'(i));
        check("oneshot_done", 32'(done_b), 1);
        pulse_b();
        pulse_b();
        repeat (10) @(posedge clk);
        #1 check("oneshot_no_more_starts", 32'(starts_b), 3);
        check("oneshot_done_held", 32'(done_b), 1);
        check("oneshot_busy", 32'(busy_b), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
